// File: rtl/camera_emulator.sv
// camera_emulator: parallel-camera source (LINE_VALID / FRAME_VALID / DATA_OUT) with ramp or checkerboard data.
// Define CAMERA_EMU_FRAME_COUNTER_EN to add FRAME_COUNT and stamp it on each frame's first pixel.
module camera_emulator #(
  parameter int H_ACTIVE = 752,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 61,
  parameter int V_BLANK  = 45
) (
  input  logic        PIXCLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        PATTERN,
  output logic        LINE_VALID,
  output logic        FRAME_VALID,
  output logic [9:0]  DATA_OUT
`ifdef CAMERA_EMU_FRAME_COUNTER_EN
  ,
  output logic [15:0] FRAME_COUNT
`endif
);

  // At least 10 bits so the ramp sum and checker bit 3 can always be sliced directly.
  localparam int CW   = ($clog2(H_ACTIVE + 1) < 10) ? 10 : $clog2(H_ACTIVE + 1);
  localparam int LW   = ($clog2(V_ACTIVE + 1) < 10) ? 10 : $clog2(V_ACTIVE + 1);
  localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BW   = ($clog2(BMAX + 1) < 1) ? 1 : $clog2(BMAX + 1);

  localparam logic [CW-1:0] COL_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] HB_LAST   = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] VB_LAST   = BW'(V_BLANK - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  state_t        state_q;
  logic [CW-1:0] col_q;
  logic [LW-1:0] line_q;
  logic [BW-1:0] blank_q;
  logic          pat_q;
  logic          lv_q;
  logic          fv_q;
  logic [9:0]    data_q;

  logic [CW-1:0] col_d;
  logic [LW-1:0] line_d;
  logic [9:0]    idle_first_d;
  logic [9:0]    vb_first_d;
  logic          vb_exit_d;

  function automatic logic [9:0] pix(input logic [9:0] c, input logic [9:0] l, input logic p);
    if (p) return (c[3] ^ l[3]) ? 10'h3FF : 10'h000;
    return c + l;
  endfunction

  assign col_d     = col_q + CW'(1);
  assign line_d    = line_q + LW'(1);
  assign vb_exit_d = (state_q == VBLANK) && (blank_q == VB_LAST);

`ifdef CAMERA_EMU_FRAME_COUNTER_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] frame_cnt_d;

  assign frame_cnt_d  = frame_cnt_q + 16'd1;
  // A frame leaving VBLANK already shows the post-increment count.
  assign idle_first_d = frame_cnt_q[9:0];
  assign vb_first_d   = frame_cnt_d[9:0];
  assign FRAME_COUNT  = frame_cnt_q;

  always_ff @(posedge PIXCLK) begin
    if (RESET)          frame_cnt_q <= '0;
    else if (vb_exit_d) frame_cnt_q <= frame_cnt_d;
  end
`else
  assign idle_first_d = pix(10'd0, 10'd0, PATTERN);
  assign vb_first_d   = idle_first_d;
`endif

  always_ff @(posedge PIXCLK) begin
    if (RESET) begin
      state_q <= IDLE;
      col_q   <= '0;
      line_q  <= '0;
      blank_q <= '0;
      pat_q   <= 1'b0;
      lv_q    <= 1'b0;
      fv_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ENABLE) begin
            state_q <= ACTIVE;
            col_q   <= '0;
            line_q  <= '0;
            pat_q   <= PATTERN;
            lv_q    <= 1'b1;
            fv_q    <= 1'b1;
            data_q  <= idle_first_d;
          end
        end
        ACTIVE: begin
          if (col_q == COL_LAST) begin
            state_q <= HBLANK;
            blank_q <= '0;
            lv_q    <= 1'b0;
            data_q  <= '0;
          end else begin
            col_q  <= col_d;
            data_q <= pix(col_d[9:0], line_q[9:0], pat_q);
          end
        end
        HBLANK: begin
          if (blank_q != HB_LAST) begin
            blank_q <= blank_q + BW'(1);
          end else if (line_q == LINE_LAST) begin
            state_q <= VBLANK;
            blank_q <= '0;
            fv_q    <= 1'b0;
          end else begin
            state_q <= ACTIVE;
            col_q   <= '0;
            line_q  <= line_d;
            lv_q    <= 1'b1;
            data_q  <= pix(10'd0, line_d[9:0], pat_q);
          end
        end
        VBLANK: begin
          if (!vb_exit_d) begin
            blank_q <= blank_q + BW'(1);
          end else if (ENABLE) begin
            state_q <= ACTIVE;
            col_q   <= '0;
            line_q  <= '0;
            pat_q   <= PATTERN;
            lv_q    <= 1'b1;
            fv_q    <= 1'b1;
            data_q  <= vb_first_d;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign LINE_VALID  = lv_q;
  assign FRAME_VALID = fv_q;
  assign DATA_OUT    = data_q;

endmodule
